clk_step_ctrl: RTL

- Receiving end of the divided clock: samples the divided `slow_tick` inside the `main_clk` domain, never clocking logic from it.
- Converts `slow_tick` rising edges into single-cycle clock-enable pulses (`ce`) for the processor datapath.
- Adds a debounced single-step mode and a halt control, so the processor can be free-run at the divided rate or stepped by hand from a board button.
- Sits between the clock divider and the processor core; the core gates all register updates with `ce`.

---
 rtl/clk_step_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/clk_step_ctrl.sv
// Turns the divided slow_tick into one-cycle clock enables in the main_clk domain, with debounced
// single-step and halt. Optional macro STEP_ON_TICK_EN aligns single steps to the next slow_tick rise.
module clk_step_ctrl #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 32
) (
    input  logic             main_clk,
    input  logic             rst_n,
    input  logic             slow_tick,
    input  logic             run_mode,
    input  logic             step_btn,
    input  logic             halt,
    output logic             ce,
    output logic [CNT_W-1:0] ce_count,
    output logic [1:0]       state
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

`ifdef STEP_ON_TICK_EN
    typedef enum logic [2:0] {
        S_HALT  = 3'd0,
        S_RUN   = 3'd1,
        S_ARMED = 3'd2,
        S_PEND  = 3'd3,
        S_HOLD  = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        S_HALT  = 2'd0,
        S_RUN   = 2'd1,
        S_ARMED = 2'd2,
        S_HOLD  = 2'd3
    } state_t;
`endif

    logic [SYNC_STAGES-1:0] tick_sync;
    logic                   tick_prev;
    logic [1:0]             run_sync;
    logic [1:0]             halt_sync;
    logic [1:0]             btn_sync;
    logic                   tick_s;
    logic                   run_mode_s;
    logic                   halt_s;
    logic                   btn_s;
    logic                   tick_rise;
    logic [DB_W-1:0]        db_cnt;
    logic                   btn_db;
    logic                   btn_db_prev;
    logic                   btn_rise;
    state_t                 st;

    assign tick_s     = tick_sync[SYNC_STAGES-1];
    assign run_mode_s = run_sync[1];
    assign halt_s     = halt_sync[1];
    assign btn_s      = btn_sync[1];
    assign tick_rise  = tick_s & ~tick_prev;
    assign btn_rise   = btn_db & ~btn_db_prev;
    assign state      = st[1:0];

    // slow_tick is only ever sampled as data; nothing is clocked from it
    always_ff @(posedge main_clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_sync <= '0;
            tick_prev <= 1'b0;
            run_sync  <= 2'b00;
            halt_sync <= 2'b00;
            btn_sync  <= 2'b00;
        end else begin
            tick_sync <= {tick_sync[SYNC_STAGES-2:0], slow_tick};
            tick_prev <= tick_s;
            run_sync  <= {run_sync[0], run_mode};
            halt_sync <= {halt_sync[0], halt};
            btn_sync  <= {btn_sync[0], step_btn};
        end
    end

    // A new button level is accepted only after DEBOUNCE_CYCLES consecutive differing samples
    always_ff @(posedge main_clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt      <= '0;
            btn_db      <= 1'b0;
            btn_db_prev <= 1'b0;
        end else begin
            btn_db_prev <= btn_db;
            if (btn_s == btn_db) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                btn_db <= btn_s;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end
    end

    always_ff @(posedge main_clk or negedge rst_n) begin
        if (!rst_n) begin
            st <= S_HALT;
            ce <= 1'b0;
        end else if (halt_s) begin
            st <= S_HALT;
            ce <= 1'b0;
        end else begin
            ce <= 1'b0;
            case (st)
                S_HALT: st <= run_mode_s ? S_RUN : S_ARMED;
                S_RUN: begin
                    // pulse follows the current state, so a mode drop never swallows a tick
                    ce <= tick_rise;
                    if (!run_mode_s) st <= S_ARMED;
                end
                S_ARMED: begin
                    if (run_mode_s) begin
                        st <= S_RUN;
                    end else if (btn_rise) begin
`ifdef STEP_ON_TICK_EN
                        st <= S_PEND;
`else
                        st <= S_HOLD;
                        ce <= 1'b1;
`endif
                    end
                end
`ifdef STEP_ON_TICK_EN
                S_PEND: begin
                    if (tick_rise) begin
                        ce <= 1'b1;
                        st <= S_HOLD;
                    end
                end
`endif
                S_HOLD: begin
                    if (!btn_db) st <= run_mode_s ? S_RUN : S_ARMED;
                end
                default: st <= S_HALT;
            endcase
        end
    end

    always_ff @(posedge main_clk or negedge rst_n) begin
        if (!rst_n) begin
            ce_count <= '0;
        end else if (ce) begin
            ce_count <= ce_count + CNT_W'(1);
        end
    end

endmodule
